mc_ctrl: RTL and testbench

MC_CTRL -- requirements
Module: mc_ctrl

---
 rtl/mc_pkg.sv | 68 ++++++
 rtl/mc_if.sv | 24 ++
 rtl/mc_decode.sv | 40 ++++
 rtl/mc_ctrl.sv | 121 ++++++++++++
 tb/tb_mc_ctrl.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_pkg.sv
// Shared constants and types for the multi-cycle MIPS-subset controller:
// opcode/funct codes, FSM state encodings, ALUOP codes and control bundles.
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_OR  = 4'b0011,
    ALU_LUI = 4'b0101
  } aluop_e;

  // One-hot instruction class; all zero means unsupported.
  typedef struct packed {
    logic nop;
    logic addu;
    logic subu;
    logic jr;
    logic j;
    logic jal;
    logic beq;
    logic addiu;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
  } instr_flags_t;

  typedef struct packed {
    logic   reg_dst;
    logic   reg31;
    logic   si_ext;
    logic   shift2;
    logic   reg_write;
    logic   alu_src2;
    logic   reg_in;
    logic   mem_write;
    logic   branch;
    logic   j;
    logic   jr;
    logic   jl;
    logic   pc_write;
    logic   ir_write;
    aluop_e alu_op;
  } ctl_t;

endpackage

// File: rtl/mc_if.sv
// Controller <-> datapath bundle: master is the controller, slave the datapath.
interface mc_if;
  import mc_pkg::*;

  logic [31:0] instr;
  logic        zero;
  logic        mem_rdy;
  logic        regDst, reg31, siExt, shift2, regWrite, ALUSrc2, regIn;
  logic        memWrite, branch, j, jr, jl, pcWrite, irWrite;
  aluop_e      ALUOP;
  state_e      state;

  modport master (
    input  instr, zero, mem_rdy,
    output regDst, reg31, siExt, shift2, regWrite, ALUSrc2, regIn,
           memWrite, branch, j, jr, jl, pcWrite, irWrite, ALUOP, state
  );

  modport slave (
    output instr, zero, mem_rdy,
    input  regDst, reg31, siExt, shift2, regWrite, ALUSrc2, regIn,
           memWrite, branch, j, jr, jl, pcWrite, irWrite, ALUOP, state
  );
endinterface

// File: rtl/mc_decode.sv
// Combinational instruction classifier: maps the IR word to one-hot flags.
module mc_decode
  import mc_pkg::*;
(
  input  logic [31:0]  instr,
  output instr_flags_t flags
);

  logic [5:0] opcode;
  logic [5:0] funct;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];

  always_comb begin
    // NOTE: every output gets a default before the case so no path infers a latch.
    flags = '0;
    if (instr == 32'h0) begin
      flags.nop = 1'b1;
    end else begin
      case (opcode)
        OP_RTYPE: begin
          flags.addu = (funct == FN_ADDU);
          flags.subu = (funct == FN_SUBU);
          flags.jr   = (funct == FN_JR);
        end
        OP_J:     flags.j     = 1'b1;
        OP_JAL:   flags.jal   = 1'b1;
        OP_BEQ:   flags.beq   = 1'b1;
        OP_ADDIU: flags.addiu = 1'b1;
        OP_ORI:   flags.ori   = 1'b1;
        OP_LUI:   flags.lui   = 1'b1;
        OP_LW:    flags.lw    = 1'b1;
        OP_SW:    flags.sw    = 1'b1;
        default:  ;
      endcase
    end
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle controller FSM (FETCH/DECODE/EXEC/MEM/WB).
// Optional MC_RETIRE_CNT_EN adds a 32-bit retired-instruction counter port.
module mc_ctrl
  import mc_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  mc_if.master        bus
`ifdef MC_RETIRE_CNT_EN
  ,
  output logic [31:0] retire_cnt
`endif
);

  instr_flags_t f;
  state_e       state_q, state_d;
  ctl_t         opnd, ctl, ctl_out;
  logic         jump, alu_ins, mem_op, to_exec;

  mc_decode u_decode (.instr(bus.instr), .flags(f));

  assign jump    = f.j | f.jal | f.jr;
  assign mem_op  = f.lw | f.sw;
  assign alu_ins = f.addu | f.subu | f.ori | f.lui | f.addiu;
  assign to_exec = (|f) & ~jump & ~f.nop;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every flop samples pre-edge values.
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  // Operand-path controls depend only on instr, so they hold steady EXEC..WB.
  always_comb begin
    opnd          = '0;
    opnd.alu_op   = (f.subu | f.beq) ? ALU_SUB :
                    f.ori            ? ALU_OR  :
                    f.lui            ? ALU_LUI : ALU_ADD;
    opnd.si_ext   = f.addiu | f.lw | f.sw | f.beq;
    opnd.alu_src2 = f.ori | f.lui | f.addiu | f.lw | f.sw;
    opnd.reg_dst  = f.ori | f.lui | f.addiu | f.lw;
    opnd.reg_in   = f.lw;
  end

  always_comb begin
    state_d = S_FETCH;
    ctl     = '0;
    case (state_q)
      S_FETCH: begin
        ctl.ir_write = 1'b1;
        ctl.pc_write = 1'b1;
        state_d      = S_DECODE;
      end
      S_DECODE: begin
        if (jump) begin
          ctl.j         = 1'b1;
          ctl.pc_write  = 1'b1;
          ctl.jr        = f.jr;
          ctl.jl        = f.jal;
          ctl.reg31     = f.jal;
          ctl.reg_write = f.jal;
        end else if (to_exec) begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        ctl = opnd;
        if (f.beq) begin
          ctl.branch   = 1'b1;
          ctl.shift2   = 1'b1;
          ctl.pc_write = bus.zero;
        end else if (mem_op) begin
          state_d = S_MEM;
        end else if (alu_ins) begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        ctl           = opnd;
        ctl.mem_write = f.sw;
        if (!bus.mem_rdy)  state_d = S_MEM;
        else if (f.lw)     state_d = S_WB;
      end
      S_WB: begin
        ctl           = opnd;
        ctl.reg_write = 1'b1;
      end
      default: ;
    endcase
  end

  assign ctl_out      = reset_n ? ctl : '0;
  assign bus.state    = reset_n ? state_q : S_FETCH;
  assign bus.regDst   = ctl_out.reg_dst;
  assign bus.reg31    = ctl_out.reg31;
  assign bus.siExt    = ctl_out.si_ext;
  assign bus.shift2   = ctl_out.shift2;
  assign bus.regWrite = ctl_out.reg_write;
  assign bus.ALUSrc2  = ctl_out.alu_src2;
  assign bus.regIn    = ctl_out.reg_in;
  assign bus.memWrite = ctl_out.mem_write;
  assign bus.branch   = ctl_out.branch;
  assign bus.j        = ctl_out.j;
  assign bus.jr       = ctl_out.jr;
  assign bus.jl       = ctl_out.jl;
  assign bus.pcWrite  = ctl_out.pc_write;
  assign bus.irWrite  = ctl_out.ir_write;
  assign bus.ALUOP    = ctl_out.alu_op;

`ifdef MC_RETIRE_CNT_EN
  logic [31:0] retire_q;

  always_ff @(posedge clk) begin
    if (!reset_n)                retire_q <= '0;
    else if (state_d == S_FETCH) retire_q <= retire_q + 32'd1;
  end

  assign retire_cnt = retire_q;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: a per-instruction trace model feeds a
// negedge compare process, plus literal checks on selected scenarios.
module tb_mc_ctrl;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  mc_if bus ();

`ifdef MC_RETIRE_CNT_EN
  logic [31:0] retire_cnt;
  bit          poke_retire = 1'b0;
`endif

  mc_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef MC_RETIRE_CNT_EN
    ,
    .retire_cnt (retire_cnt)
`endif
  );

  typedef struct packed {
    logic       regDst, reg31, siExt, shift2, regWrite, ALUSrc2, regIn;
    logic       memWrite, branch, j, jr, jl, pcWrite, irWrite;
    logic [3:0] ALUOP;
    logic [2:0] state;
  } obs_t;

  typedef struct {
    logic rst;
    logic z;
    logic rdy;
    obs_t e;
  } step_t;

  step_t tr[$];
  obs_t  exp_q[$];
  obs_t  got[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc_idx  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.regDst = bus.regDst;   o.reg31 = bus.reg31;     o.siExt = bus.siExt;
    o.shift2 = bus.shift2;   o.regWrite = bus.regWrite; o.ALUSrc2 = bus.ALUSrc2;
    o.regIn = bus.regIn;     o.memWrite = bus.memWrite; o.branch = bus.branch;
    o.j = bus.j;             o.jr = bus.jr;           o.jl = bus.jl;
    o.pcWrite = bus.pcWrite; o.irWrite = bus.irWrite;
    o.ALUOP = bus.ALUOP;     o.state = bus.state;
    return o;
  endfunction

  // Expected outputs for one mnemonic in one state (0=F,1=D,2=E,3=M,4=W).
  function automatic obs_t expect_for(input string op, input int st, input logic z);
    obs_t       o = '0;
    logic [3:0] aop = 4'b0000;
    logic       si = 1'b0, src2 = 1'b0, rdst = 1'b0, rin = 1'b0;
    case (op)
      "subu":  aop = 4'b0001;
      "ori":   begin aop = 4'b0011; src2 = 1'b1; rdst = 1'b1; end
      "lui":   begin aop = 4'b0101; src2 = 1'b1; rdst = 1'b1; end
      "addiu": begin si = 1'b1; src2 = 1'b1; rdst = 1'b1; end
      "lw":    begin si = 1'b1; src2 = 1'b1; rdst = 1'b1; rin = 1'b1; end
      "sw":    begin si = 1'b1; src2 = 1'b1; end
      "beq":   begin aop = 4'b0001; si = 1'b1; end
      default: ;
    endcase
    o.state = st[2:0];
    if (st == 0) begin
      o.irWrite = 1'b1;
      o.pcWrite = 1'b1;
    end else if (st == 1) begin
      if (op == "j" || op == "jal" || op == "jr") begin
        o.j = 1'b1;
        o.pcWrite = 1'b1;
      end
      if (op == "jal") begin
        o.jl = 1'b1; o.reg31 = 1'b1; o.regWrite = 1'b1;
      end
      if (op == "jr") o.jr = 1'b1;
    end else begin
      o.ALUOP = aop; o.siExt = si; o.ALUSrc2 = src2; o.regDst = rdst; o.regIn = rin;
      if (st == 2 && op == "beq") begin
        o.branch = 1'b1; o.shift2 = 1'b1; o.pcWrite = z;
      end
      if (st == 3 && op == "sw") o.memWrite = 1'b1;
      if (st == 4) o.regWrite = 1'b1;
    end
    return o;
  endfunction

  // Build the cycle trace of one instruction; abort_at >= 0 asserts reset there.
  function automatic void build(input string op, input logic z, input int waits, input int abort_at);
    int    sts[$];
    bit    ex = 1'b0, mem = 1'b0, wb = 1'b0;
    int    k = 0;
    step_t s;
    case (op)
      "addu", "subu", "ori", "lui", "addiu": begin ex = 1'b1; wb = 1'b1; end
      "lw":  begin ex = 1'b1; mem = 1'b1; wb = 1'b1; end
      "sw":  begin ex = 1'b1; mem = 1'b1; end
      "beq": ex = 1'b1;
      default: ;
    endcase
    sts.push_back(0);
    sts.push_back(1);
    if (ex) sts.push_back(2);
    if (mem) for (int i = 0; i <= waits; i++) sts.push_back(3);
    if (wb) sts.push_back(4);
    foreach (sts[i]) begin
      s.rst = 1'b1;
      s.z   = z;
      s.rdy = 1'b1;
      if (sts[i] == 3) begin
        s.rdy = (k == waits);
        k++;
      end
      if (i == abort_at) begin
        s.rst = 1'b0;
        s.e   = '0;
        tr.push_back(s);
        break;
      end
      s.e = expect_for(op, sts[i], z);
      tr.push_back(s);
    end
  endfunction

  task automatic play(input logic [31:0] ins);
    got.delete();
    foreach (tr[i]) begin
      @(posedge clk);
      #1;
      reset_n     = tr[i].rst;
      bus.instr   = ins;
      bus.zero    = tr[i].z;
      bus.mem_rdy = tr[i].rdy;
      exp_q.push_back(tr[i].e);
`ifdef MC_RETIRE_CNT_EN
      if (i == 0 && poke_retire) dut.retire_q = 32'hFFFF_FFFF;
`endif
      #1;
      got.push_back(sample());
    end
    tr.delete();
  endtask

  task automatic run(input string op, input logic [31:0] ins, input logic z,
                     input int waits, input int abort_at);
    build(op, z, waits, abort_at);
    play(ins);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      obs_t e;
      e = exp_q.pop_front();
      check($sformatf("cycle%0d", cyc_idx), 32'(sample()), 32'(e));
      cyc_idx++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected end");
    $fatal(1);
  end

  initial begin
    step_t r;
    int    m;
    reset_n     = 1'b0;
    bus.instr   = 32'h0;
    bus.zero    = 1'b0;
    bus.mem_rdy = 1'b1;

    r.rst = 1'b0; r.z = 1'b0; r.rdy = 1'b1; r.e = '0;
    tr.push_back(r);
    tr.push_back(r);
    play(32'h0);

    run("addu", 32'h0022_1821, 1'b0, 0, -1);
    check("addu_len", got.size(), 4);
    check("addu_st0", 32'(got[0].state), 0);
    check("addu_st1", 32'(got[1].state), 1);
    check("addu_st2", 32'(got[2].state), 2);
    check("addu_st3", 32'(got[3].state), 4);
    check("addu_rw_exec", 32'(got[2].regWrite), 0);
    check("addu_rw_wb", 32'(got[3].regWrite), 1);
    check("addu_aluop", 32'(got[2].ALUOP), 0);

    run("subu",  32'h0022_2023, 1'b0, 0, -1);
    run("ori",   32'h3425_00FF, 1'b0, 0, -1);
    run("lui",   32'h3C06_1234, 1'b0, 0, -1);
    run("addiu", 32'h2427_FFFC, 1'b1, 0, -1);
    run("lw",    32'h8C28_0004, 1'b0, 0, -1);

    run("lw",    32'h8C28_0004, 1'b0, 3, -1);
    m = 0;
    foreach (got[i]) if (got[i].state == 3'd3) m++;
    check("lw_mem_cycles", m, 4);
    check("lw_latency", got.size(), 8);
    check("lw_wb_regin", 32'(got[7].regIn), 1);
    check("lw_wb_regwrite", 32'(got[7].regWrite), 1);

    run("sw",    32'hAC28_0008, 1'b0, 0, -1);
    run("sw",    32'hAC28_0008, 1'b0, 2, -1);

    run("beq",   32'h1022_0003, 1'b1, 0, -1);
    check("beq_z1_pcwrite", 32'(got[2].pcWrite), 1);
    run("beq",   32'h1022_0003, 1'b0, 0, -1);
    check("beq_z0_pcwrite", 32'(got[2].pcWrite), 0);
    check("beq_z0_branch", 32'(got[2].branch), 1);

    run("j",     32'h0800_0100, 1'b0, 0, -1);
    run("jal",   32'h0C00_0100, 1'b0, 0, -1);
    check("jal_len", got.size(), 2);
    check("jal_decode_bits",
          {got[1].reg31, got[1].jl, got[1].regWrite, got[1].pcWrite}, 32'hF);
    run("jr",    32'h03E0_0008, 1'b0, 0, -1);
    run("nop",   32'h0000_0000, 1'b0, 0, -1);
    run("bad",   32'hFC00_0000, 1'b0, 0, -1);
    run("bad",   32'h0022_1824, 1'b0, 0, -1);

    run("sw",    32'hAC28_0008, 1'b0, 5, 5);
    check("sw_abort_outputs", 32'(got[5]), 0);
    run("nop",   32'h0000_0000, 1'b0, 0, -1);
    check("after_abort_state", 32'(got[0].state), 0);

    run("jal",   32'h0C00_0100, 1'b0, 0, 1);
    run("lw",    32'h8C28_0004, 1'b0, 1, 5);
    run("addu",  32'h0022_1821, 1'b1, 0, -1);

`ifdef MC_RETIRE_CNT_EN
    poke_retire = 1'b1;
    run("nop",   32'h0000_0000, 1'b0, 0, -1);
    poke_retire = 1'b0;
    @(posedge clk);
    #1;
    check("retire_wrap", retire_cnt, 32'h0);
`endif

    @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
